// File: rtl/soc_system_key_pkg.sv
// ----------------------------------------------------------------------------
// soc_system_key_pkg
// Shared defaults and helpers for the key conditioner block.
//   KEY_WIDTH_DEF            : default number of key channels
//   KEY_DEBOUNCE_CYCLES_DEF  : default stable-cycle count (1 ms at 50 MHz)
//   KEY_ACTIVE_LOW_DEF       : default pin polarity (1 = pin low when pressed)
//   key_cnt_width()          : width of the per-channel debounce counter
// ----------------------------------------------------------------------------
package soc_system_key_pkg;

    localparam int KEY_WIDTH_DEF           = 2;
    localparam int KEY_DEBOUNCE_CYCLES_DEF = 50000;
    localparam bit KEY_ACTIVE_LOW_DEF      = 1'b1;

    // The counter only has to reach DEBOUNCE_CYCLES-1, so clog2 bits suffice.
    // Clamp to one bit so a degenerate parameter still elaborates.
    function automatic int key_cnt_width(input int cycles);
        return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
    endfunction

endpackage : soc_system_key_pkg

// File: rtl/soc_system_key_conditioner_debounce_bit.sv
// ----------------------------------------------------------------------------
// soc_system_key_debounce_bit
// One key channel: 2-flop synchronizer, polarity normalisation, debounce
// counter, accepted level and press/release edge pulses.
//   clk, reset   : clock, synchronous active-high reset
//   key_raw      : asynchronous pin
//   key_level    : debounced level, 1 = pressed
//   key_press    : one-cycle pulse the cycle after key_level rises
//   key_release  : one-cycle pulse the cycle after key_level falls
//   press_set    : combinational press event, aligned with key_press's load
//                  edge so the parent can set its capture bit alongside it
// ----------------------------------------------------------------------------
module soc_system_key_debounce_bit
    import soc_system_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEF,
    parameter bit ACTIVE_LOW      = KEY_ACTIVE_LOW_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic press_set
);

    localparam int               CNT_W        = key_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             RAW_RELEASED = logic'(ACTIVE_LOW);

    logic             sync_p0;
    logic             sync_p1;
    logic             norm;
    logic             mismatch;
    logic             level_d;
    logic             release_set;
    logic             level_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // ---- stage p0/p1: synchronizer, reset to the idle pin level ----
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= RAW_RELEASED;
            sync_p1 <= RAW_RELEASED;
        end else begin
            sync_p0 <= key_raw;
            sync_p1 <= sync_p0;
        end
    end

    assign norm     = ACTIVE_LOW ? ~sync_p1 : sync_p1;
    assign mismatch = norm ^ key_level;

    // Counter runs only while the input disagrees with the accepted level;
    // any agreeing cycle restarts it, so a bounce never accumulates.
    // Reaching CNT_LAST with the mismatch still present accepts the change
    // and clears the counter, so it can never wrap.
    always_comb begin
        cnt_nxt   = '0;
        level_nxt = key_level;
        if (mismatch) begin
            if (cnt == CNT_LAST) begin
                level_nxt = ~key_level;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // ---- stage p2: debounce state and accepted level ----
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            key_level <= 1'b0;
            level_d   <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            key_level <= level_nxt;
            level_d   <= key_level;
        end
    end

    assign press_set   =  key_level & ~level_d;
    assign release_set = ~key_level &  level_d;

    // ---- stage p3: registered edge pulses ----
    always_ff @(posedge clk) begin
        if (reset) begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= press_set;
            key_release <= release_set;
        end
    end

endmodule : soc_system_key_debounce_bit

// File: rtl/soc_system_key_conditioner.sv
// ----------------------------------------------------------------------------
// soc_system_key_conditioner
// Debounces WIDTH board keys and presents level, edge pulses, sticky press
// capture bits and a masked interrupt.
//   clk, reset   : clock, synchronous active-high reset
//   key_raw      : asynchronous key pins
//   capture_clr  : write-1-to-clear strobes for capture
//   irq_mask     : per-channel interrupt enable
//   key_level    : debounced level, 1 = pressed (feeds the input PIO)
//   key_press    : one-cycle pulse per accepted press
//   key_release  : one-cycle pulse per accepted release
//   capture      : sticky press-capture bits
//   irq          : registered OR of capture & irq_mask
// ----------------------------------------------------------------------------
module soc_system_key_conditioner
    import soc_system_key_pkg::*;
#(
    parameter int WIDTH           = KEY_WIDTH_DEF,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEF,
    parameter bit ACTIVE_LOW      = KEY_ACTIVE_LOW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_raw,
    input  logic [WIDTH-1:0] capture_clr,
    input  logic [WIDTH-1:0] irq_mask,
    output logic [WIDTH-1:0] key_level,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release,
    output logic [WIDTH-1:0] capture,
    output logic             irq
);

    logic [WIDTH-1:0] press_set;

    for (genvar ch = 0; ch < WIDTH; ch++) begin : g_chan
        soc_system_key_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_bit (
            .clk         (clk),
            .reset       (reset),
            .key_raw     (key_raw[ch]),
            .key_level   (key_level[ch]),
            .key_press   (key_press[ch]),
            .key_release (key_release[ch]),
            .press_set   (press_set[ch])
        );
    end

    // ---- capture and interrupt stage ----
    // Set is OR'd in after the clear so a press coinciding with a clear
    // strobe is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            capture <= '0;
            irq     <= 1'b0;
        end else begin
            capture <= (capture & ~capture_clr) | press_set;
            irq     <= |(capture & irq_mask);
        end
    end

endmodule : soc_system_key_conditioner

// File: tb/tb_soc_system_key_conditioner.sv
module tb_soc_system_key_conditioner;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] key_raw;
    logic [1:0] capture_clr;
    logic [1:0] irq_mask;
    logic [1:0] key_level;
    logic [1:0] key_press;
    logic [1:0] key_release;
    logic [1:0] capture;
    logic       irq;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    soc_system_key_conditioner #(
        .WIDTH           (2),
        .DEBOUNCE_CYCLES (D),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_raw     (key_raw),
        .capture_clr (capture_clr),
        .irq_mask    (irq_mask),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .capture     (capture),
        .irq         (irq)
    );

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: a key level flips once the synchronized pin has
    // disagreed with it for D consecutive edges. Pins take two edges to be
    // seen, and read as released for two edges after a reset. Pulses follow
    // one edge after a flip; capture/irq follow from the pulses and strobes.
    typedef struct {
        int         cyc;
        int         last_rst;
        logic [1:0] hist [4];
        int         run  [2];
        int         tog  [2];
        logic [1:0] lvl;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] cap;
        logic       irq;
    } model_t;

    model_t m;

    function automatic model_t model_step(input model_t s, input logic rst, input logic [1:0] raw,
                                          input logic [1:0] clr, input logic [1:0] mask);
        model_t     n;
        logic [1:0] norm;
        n = s;
        n.cyc = s.cyc + 1;
        n.hist[n.cyc % 4] = raw;
        if (rst) begin
            n.last_rst = n.cyc;
            n.lvl = '0; n.press = '0; n.rel = '0; n.cap = '0; n.irq = 1'b0;
            for (int c = 0; c < 2; c++) begin
                n.run[c] = 0;
                n.tog[c] = -100;
            end
            return n;
        end
        n.press = '0;
        n.rel   = '0;
        for (int c = 0; c < 2; c++) begin
            if (s.tog[c] == n.cyc - 1) begin
                if (s.lvl[c]) n.press[c] = 1'b1;
                else          n.rel[c]   = 1'b1;
            end
        end
        n.irq = |(s.cap & mask);
        n.cap = (s.cap & ~clr) | n.press;
        norm  = (n.cyc - 2 > s.last_rst) ? ~s.hist[(n.cyc - 2) % 4] : 2'b00;
        for (int c = 0; c < 2; c++) begin
            if (norm[c] != s.lvl[c]) begin
                n.run[c] = s.run[c] + 1;
                if (n.run[c] == D) begin
                    n.lvl[c] = ~s.lvl[c];
                    n.tog[c] = n.cyc;
                    n.run[c] = 0;
                end
            end else begin
                n.run[c] = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk) m <= model_step(m, reset, key_raw, capture_clr, irq_mask);

    always @(negedge clk) begin
        if (chk_en) begin
            chk_eq("model_key_level",   32'(key_level),   32'(m.lvl));
            chk_eq("model_key_press",   32'(key_press),   32'(m.press));
            chk_eq("model_key_release", 32'(key_release), 32'(m.rel));
            chk_eq("model_capture",     32'(capture),     32'(m.cap));
            chk_eq("model_irq",         32'(irq),         32'(m.irq));
        end
    end

    task automatic wait_level(input int ch, input logic tgt, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (key_level[ch] !== tgt && n < 40);
    endtask

    int         n;
    int         hold [2];
    logic [1:0] rawv;

    initial begin
        reset       = 1'b1;
        key_raw     = 2'b11;
        capture_clr = 2'b00;
        irq_mask    = 2'b01;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk_eq("rst_key_level",   32'(key_level),   0);
        chk_eq("rst_key_press",   32'(key_press),   0);
        chk_eq("rst_key_release", 32'(key_release), 0);
        chk_eq("rst_capture",     32'(capture),     0);
        chk_eq("rst_irq",         32'(irq),         0);
        reset = 1'b0;
        repeat (12) @(negedge clk);

        // single press on channel 0
        key_raw = 2'b10;
        wait_level(0, 1'b1, n);
        chk_eq("press0_latency", n, 10);
        @(posedge clk); #1;
        chk_eq("press0_pulse",   32'(key_press), 32'h1);
        chk_eq("press0_capture", 32'(capture),   32'h1);
        @(posedge clk); #1;
        chk_eq("press0_irq", 32'(irq), 32'h1);

        @(negedge clk); key_raw = 2'b11;
        wait_level(0, 1'b0, n);
        chk_eq("release0_latency", n, 10);
        @(posedge clk); #1;
        chk_eq("release0_pulse", 32'(key_release), 32'h1);

        // second press with a clear strobe in the same cycle: set wins
        @(negedge clk); key_raw = 2'b10;
        wait_level(0, 1'b1, n);
        capture_clr = 2'b01;
        @(posedge clk); #1;
        capture_clr = 2'b00;
        chk_eq("set_wins_capture", 32'(capture[0]), 32'h1);
        @(negedge clk); capture_clr = 2'b01;
        @(posedge clk); #1;
        capture_clr = 2'b00;
        chk_eq("clr_capture", 32'(capture[0]), 32'h0);
        @(posedge clk); #1;
        chk_eq("clr_irq", 32'(irq), 32'h0);

        // both channels together
        @(negedge clk); key_raw = 2'b11;
        wait_level(0, 1'b0, n);
        @(negedge clk); key_raw = 2'b00;
        wait_level(0, 1'b1, n);
        chk_eq("both_latency", n, 10);
        chk_eq("both_level", 32'(key_level), 32'h3);
        @(posedge clk); #1;
        chk_eq("both_press", 32'(key_press), 32'h3);
        chk_eq("both_capture", 32'(capture), 32'h3);
        irq_mask = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("mask_off_irq", 32'(irq), 32'h0);
        irq_mask = 2'b10;
        @(posedge clk); #1;
        chk_eq("mask_on_irq", 32'(irq), 32'h1);

        @(negedge clk); key_raw = 2'b11;
        wait_level(1, 1'b0, n);
        chk_eq("both_rel_latency", n, 10);
        chk_eq("both_rel_level", 32'(key_level), 32'h0);
        @(posedge clk); #1;
        chk_eq("both_release", 32'(key_release), 32'h3);

        // bounce on channel 1 never reaches D stable cycles
        @(negedge clk); capture_clr = 2'b11; irq_mask = 2'b01;
        @(negedge clk); capture_clr = 2'b00;
        key_raw = 2'b01; repeat (5) @(negedge clk);
        key_raw = 2'b11; repeat (2) @(negedge clk);
        key_raw = 2'b01; repeat (5) @(negedge clk);
        key_raw = 2'b11; repeat (15) @(negedge clk);
        chk_eq("bounce_level1",   32'(key_level[1]), 32'h0);
        chk_eq("bounce_capture1", 32'(capture[1]),   32'h0);

        // reset in the middle of a count
        key_raw = 2'b10;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_eq("midrst_level",   32'(key_level), 32'h0);
        chk_eq("midrst_capture", 32'(capture),   32'h0);
        chk_eq("midrst_irq",     32'(irq),       32'h0);
        reset = 1'b0;
        wait_level(0, 1'b1, n);
        chk_eq("midrst_latency", n, 10);

        // randomized traffic against the model
        hold[0] = 0;
        hold[1] = 0;
        rawv    = key_raw;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                if (hold[c] == 0) begin
                    rawv[c] = 1'($urandom_range(0, 1));
                    hold[c] = int'($urandom_range(1, 14));
                end
                hold[c]--;
            end
            key_raw     = rawv;
            capture_clr = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            if ($urandom_range(0, 15) == 0) irq_mask = 2'($urandom);
            reset = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        reset   = 1'b0;
        key_raw = 2'b11;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule : tb_soc_system_key_conditioner
